// File: rtl/axi_lite_sram_slave.sv
// AXI4-Lite slave in front of a word-organised on-chip RAM.
// Serves as the data-memory slave for the RV32I load/store path.
//
// Ports:
//   AXI_ACLK, AXI_ARESET         clock, synchronous active-high reset
//   AXI_AW* / AXI_W* / AXI_B*    write address, write data, write response
//   AXI_AR* / AXI_R*             read address, read data
// Out-of-range accesses (below BASE_ADDR or index >= DEPTH) answer SLVERR.
// Writes are dropped and reads return zero in that case. Every output is registered.
module axi_lite_sram_slave #(
    parameter int unsigned           DEPTH        = 1024,
    parameter int unsigned           AXI_AWIDTH   = 32,
    parameter int unsigned           AXI_DWIDTH   = 32,
    parameter int unsigned           READ_LATENCY = 1,
    parameter logic [AXI_AWIDTH-1:0] BASE_ADDR    = '0
) (
    input  logic                    AXI_ACLK,
    input  logic                    AXI_ARESET,
    input  logic [AXI_AWIDTH-1:0]   AXI_AWADDR,
    input  logic                    AXI_AWVALID,
    output logic                    AXI_AWREADY,
    input  logic [AXI_DWIDTH-1:0]   AXI_WDATA,
    input  logic [AXI_DWIDTH/8-1:0] AXI_WSTRB,
    input  logic                    AXI_WVALID,
    output logic                    AXI_WREADY,
    output logic [1:0]              AXI_BRESP,
    output logic                    AXI_BVALID,
    input  logic                    AXI_BREADY,
    input  logic [AXI_AWIDTH-1:0]   AXI_ARADDR,
    input  logic                    AXI_ARVALID,
    output logic                    AXI_ARREADY,
    output logic [AXI_DWIDTH-1:0]   AXI_RDATA,
    output logic [1:0]              AXI_RRESP,
    output logic                    AXI_RVALID,
    input  logic                    AXI_RREADY
);

    localparam int unsigned NB = AXI_DWIDTH / 8;
    localparam int unsigned SH = $clog2(NB);
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef logic [AXI_AWIDTH-1:0] addr_t;
    typedef enum logic       {W_IDLE, W_RESP}         w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_LAT, R_DATA} r_state_t;

    function automatic addr_t word_index(input addr_t a);
        return (a - BASE_ADDR) >> SH;
    endfunction

    function automatic logic in_range(input addr_t a);
        return (a >= BASE_ADDR) && (word_index(a) < addr_t'(DEPTH));
    endfunction

    logic [AXI_DWIDTH-1:0] mem [DEPTH];

    // Write channel state
    w_state_t              w_state,  w_state_n;
    logic                  aw_held,  aw_held_n, w_held, w_held_n;
    addr_t                 awaddr_q, awaddr_n;
    logic [AXI_DWIDTH-1:0] wdata_q,  wdata_n;
    logic [NB-1:0]         wstrb_q,  wstrb_n;
    logic                  awready_q, awready_n, wready_q, wready_n;
    logic                  bvalid_q, bvalid_n;
    logic [1:0]            bresp_q,  bresp_n;
    logic                  wr_en;
    addr_t                 widx_full;

    always_comb begin
        w_state_n = w_state;
        aw_held_n = aw_held;
        w_held_n  = w_held;
        awaddr_n  = awaddr_q;
        wdata_n   = wdata_q;
        wstrb_n   = wstrb_q;
        awready_n = awready_q;
        wready_n  = wready_q;
        bvalid_n  = bvalid_q;
        bresp_n   = bresp_q;
        wr_en     = 1'b0;
        widx_full = word_index(awaddr_q);
        case (w_state)
            W_IDLE: begin
                if (aw_held && w_held) begin
                    wr_en     = in_range(awaddr_q);
                    bvalid_n  = 1'b1;
                    bresp_n   = in_range(awaddr_q) ? RESP_OKAY : RESP_SLVERR;
                    w_state_n = W_RESP;
                end else begin
                    // Each half is captured on its own; READY stays low once held.
                    if (!aw_held) begin
                        if (awready_q && AXI_AWVALID) begin
                            aw_held_n = 1'b1;
                            awaddr_n  = AXI_AWADDR;
                            awready_n = 1'b0;
                        end else begin
                            awready_n = 1'b1;
                        end
                    end
                    if (!w_held) begin
                        if (wready_q && AXI_WVALID) begin
                            w_held_n = 1'b1;
                            wdata_n  = AXI_WDATA;
                            wstrb_n  = AXI_WSTRB;
                            wready_n = 1'b0;
                        end else begin
                            wready_n = 1'b1;
                        end
                    end
                end
            end
            W_RESP: begin
                if (AXI_BREADY) begin
                    bvalid_n  = 1'b0;
                    aw_held_n = 1'b0;
                    w_held_n  = 1'b0;
                    w_state_n = W_IDLE;
                end
            end
            default: w_state_n = W_IDLE;
        endcase
    end

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_ARESET) begin
            w_state   <= W_IDLE;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            w_state   <= w_state_n;
            aw_held   <= aw_held_n;
            w_held    <= w_held_n;
            awaddr_q  <= awaddr_n;
            wdata_q   <= wdata_n;
            wstrb_q   <= wstrb_n;
            awready_q <= awready_n;
            wready_q  <= wready_n;
            bvalid_q  <= bvalid_n;
            bresp_q   <= bresp_n;
        end
    end

    always_ff @(posedge AXI_ACLK) begin
        if (!AXI_ARESET && wr_en) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (wstrb_q[b]) mem[widx_full[IW-1:0]][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

    // Read channel state
    r_state_t              r_state,  r_state_n;
    addr_t                 araddr_q, araddr_n;
    logic [1:0]            lat_cnt,  lat_cnt_n;
    logic                  arready_q, arready_n;
    logic                  rvalid_q, rvalid_n;
    logic [1:0]            rresp_q,  rresp_n;
    logic [AXI_DWIDTH-1:0] rdata_q,  rdata_n;
    addr_t                 ridx_full;
    logic [AXI_DWIDTH-1:0] rd_word;

    // Write-first: bytes committed on the sampling edge are forwarded into the read.
    always_comb begin
        ridx_full = word_index(araddr_q);
        rd_word   = mem[ridx_full[IW-1:0]];
        if (wr_en && (widx_full == ridx_full)) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (wstrb_q[b]) rd_word[8*b +: 8] = wdata_q[8*b +: 8];
            end
        end
    end

    // R_DATA with RVALID low is the sampling cycle; that lets READ_LATENCY=1 bypass R_LAT.
    always_comb begin
        r_state_n = r_state;
        araddr_n  = araddr_q;
        lat_cnt_n = lat_cnt;
        arready_n = arready_q;
        rvalid_n  = rvalid_q;
        rresp_n   = rresp_q;
        rdata_n   = rdata_q;
        case (r_state)
            R_IDLE: begin
                if (arready_q && AXI_ARVALID) begin
                    araddr_n  = AXI_ARADDR;
                    arready_n = 1'b0;
                    if (READ_LATENCY > 1) begin
                        r_state_n = R_LAT;
                        lat_cnt_n = 2'(READ_LATENCY - 2);
                    end else begin
                        r_state_n = R_DATA;
                    end
                end else begin
                    arready_n = 1'b1;
                end
            end
            R_LAT: begin
                if (lat_cnt == 2'd0) r_state_n = R_DATA;
                else                 lat_cnt_n = lat_cnt - 2'd1;
            end
            R_DATA: begin
                if (!rvalid_q) begin
                    rvalid_n = 1'b1;
                    if (in_range(araddr_q)) begin
                        rdata_n = rd_word;
                        rresp_n = RESP_OKAY;
                    end else begin
                        rdata_n = '0;
                        rresp_n = RESP_SLVERR;
                    end
                end else if (AXI_RREADY) begin
                    rvalid_n  = 1'b0;
                    r_state_n = R_IDLE;
                end
            end
            default: r_state_n = R_IDLE;
        endcase
    end

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_ARESET) begin
            r_state   <= R_IDLE;
            araddr_q  <= '0;
            lat_cnt   <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            r_state   <= r_state_n;
            araddr_q  <= araddr_n;
            lat_cnt   <= lat_cnt_n;
            arready_q <= arready_n;
            rvalid_q  <= rvalid_n;
            rresp_q   <= rresp_n;
            rdata_q   <= rdata_n;
        end
    end

    assign AXI_AWREADY = awready_q;
    assign AXI_WREADY  = wready_q;
    assign AXI_BVALID  = bvalid_q;
    assign AXI_BRESP   = bresp_q;
    assign AXI_ARREADY = arready_q;
    assign AXI_RVALID  = rvalid_q;
    assign AXI_RRESP   = rresp_q;
    assign AXI_RDATA   = rdata_q;

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Bench for axi_lite_sram_slave: instance 0 uses READ_LATENCY=1, instance 1 uses READ_LATENCY=3.
module tb_axi_lite_sram_slave;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst     [2];
    logic [31:0] awaddr  [2];
    logic        awvalid [2];
    logic        awready [2];
    logic [31:0] wdata   [2];
    logic [3:0]  wstrb   [2];
    logic        wvalid  [2];
    logic        wready  [2];
    logic [1:0]  bresp   [2];
    logic        bvalid  [2];
    logic        bready  [2];
    logic [31:0] araddr  [2];
    logic        arvalid [2];
    logic        arready [2];
    logic [31:0] rdata   [2];
    logic [1:0]  rresp   [2];
    logic        rvalid  [2];
    logic        rready  [2];

    axi_lite_sram_slave #(.DEPTH(1024), .AXI_AWIDTH(32), .AXI_DWIDTH(32), .READ_LATENCY(1), .BASE_ADDR(32'h0)) u_lat1 (
        .AXI_ACLK(clk), .AXI_ARESET(rst[0]),
        .AXI_AWADDR(awaddr[0]), .AXI_AWVALID(awvalid[0]), .AXI_AWREADY(awready[0]),
        .AXI_WDATA(wdata[0]), .AXI_WSTRB(wstrb[0]), .AXI_WVALID(wvalid[0]), .AXI_WREADY(wready[0]),
        .AXI_BRESP(bresp[0]), .AXI_BVALID(bvalid[0]), .AXI_BREADY(bready[0]),
        .AXI_ARADDR(araddr[0]), .AXI_ARVALID(arvalid[0]), .AXI_ARREADY(arready[0]),
        .AXI_RDATA(rdata[0]), .AXI_RRESP(rresp[0]), .AXI_RVALID(rvalid[0]), .AXI_RREADY(rready[0]));

    axi_lite_sram_slave #(.DEPTH(1024), .AXI_AWIDTH(32), .AXI_DWIDTH(32), .READ_LATENCY(3), .BASE_ADDR(32'h0)) u_lat3 (
        .AXI_ACLK(clk), .AXI_ARESET(rst[1]),
        .AXI_AWADDR(awaddr[1]), .AXI_AWVALID(awvalid[1]), .AXI_AWREADY(awready[1]),
        .AXI_WDATA(wdata[1]), .AXI_WSTRB(wstrb[1]), .AXI_WVALID(wvalid[1]), .AXI_WREADY(wready[1]),
        .AXI_BRESP(bresp[1]), .AXI_BVALID(bvalid[1]), .AXI_BREADY(bready[1]),
        .AXI_ARADDR(araddr[1]), .AXI_ARVALID(arvalid[1]), .AXI_ARREADY(arready[1]),
        .AXI_RDATA(rdata[1]), .AXI_RRESP(rresp[1]), .AXI_RVALID(rvalid[1]), .AXI_RREADY(rready[1]));

    int errors = 0;
    int checks = 0;

    typedef struct { logic [31:0] data; logic [1:0] resp; } rd_exp_t;
    rd_exp_t    rd_q [$];
    logic [1:0] wr_q [$];
    bit [31:0]  shadow [2][1024];

    // Reference model: byte-merge into the shadow RAM and queue the expected response.
    function automatic void expect_write(input int d, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        if (addr < 32'h1000) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) shadow[d][addr[11:2]][8*b +: 8] = data[8*b +: 8];
            wr_q.push_back(2'b00);
        end else begin
            wr_q.push_back(2'b10);
        end
    endfunction

    function automatic void expect_read(input int d, input logic [31:0] addr);
        rd_exp_t e;
        if (addr < 32'h1000) begin e.data = shadow[d][addr[11:2]]; e.resp = 2'b00; end
        else                 begin e.data = 32'h0;                e.resp = 2'b10; end
        rd_q.push_back(e);
    endfunction

    task automatic do_write(input int d, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_delay, input int bhold,
                            output logic [1:0] resp, output int bedges, output bit ok, output bit stable);
        int n;
        bit aw_done, w_done, aw_hs, w_hs;
        ok = 1; stable = 1; bedges = 0; resp = 2'bxx;
        aw_done = 0; w_done = 0; n = 0;
        awaddr[d] = addr; wdata[d] = data; wstrb[d] = strb;
        wvalid[d] = 1'b1; awvalid[d] = (aw_delay == 0);
        while (!(aw_done && w_done)) begin
            aw_hs = awvalid[d] && awready[d];
            w_hs  = wvalid[d] && wready[d];
            @(negedge clk);
            n++;
            if (aw_hs) begin aw_done = 1; awvalid[d] = 1'b0; end
            if (w_hs)  begin w_done  = 1; wvalid[d]  = 1'b0; end
            if (!aw_done && n >= aw_delay) awvalid[d] = 1'b1;
            if (n > 50) begin ok = 0; awvalid[d] = 1'b0; wvalid[d] = 1'b0; return; end
        end
        while (!bvalid[d]) begin
            @(negedge clk);
            bedges++;
            if (bedges > 50) begin ok = 0; return; end
        end
        resp = bresp[d];
        repeat (bhold) begin
            @(negedge clk);
            if (bvalid[d] !== 1'b1 || bresp[d] !== resp || awready[d] !== 1'b0 || wready[d] !== 1'b0) stable = 0;
        end
        bready[d] = 1'b1;
        @(negedge clk);
        bready[d] = 1'b0;
    endtask

    task automatic do_read(input int d, input logic [31:0] addr, input int rhold,
                           output logic [31:0] data, output logic [1:0] resp, output int lat,
                           output bit ok, output bit stable);
        int n;
        ok = 1; stable = 1; lat = 0; n = 0; data = 'x; resp = 'x;
        araddr[d] = addr; arvalid[d] = 1'b1;
        while (!arready[d]) begin
            @(negedge clk);
            n++;
            if (n > 50) begin ok = 0; arvalid[d] = 1'b0; return; end
        end
        @(negedge clk);
        arvalid[d] = 1'b0;
        while (!rvalid[d]) begin
            @(negedge clk);
            lat++;
            if (lat > 50) begin ok = 0; return; end
        end
        data = rdata[d]; resp = rresp[d];
        repeat (rhold) begin
            @(negedge clk);
            if (rvalid[d] !== 1'b1 || rdata[d] !== data || rresp[d] !== resp || arready[d] !== 1'b0) stable = 0;
        end
        rready[d] = 1'b1;
        @(negedge clk);
        rready[d] = 1'b0;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; awvalid[d] = 0; wvalid[d] = 0; bready[d] = 0; arvalid[d] = 0; rready[d] = 0;
            awaddr[d] = '0; wdata[d] = '0; wstrb[d] = '0; araddr[d] = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({awready[d], wready[d], arready[d], bvalid[d], rvalid[d], bresp[d], rresp[d]} !== 9'b0) begin
                errors++;
                $display("FAIL reset_ctrl[%0d]: got %b expected %b", d,
                         {awready[d], wready[d], arready[d], bvalid[d], rvalid[d], bresp[d], rresp[d]}, 9'b0);
            end
            checks++;
            if (rdata[d] !== 32'h0) begin errors++; $display("FAIL reset_rdata[%0d]: got %h expected 0", d, rdata[d]); end
            rst[d] = 1'b0;
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({awready[d], wready[d], arready[d]} !== 3'b111) begin
                errors++;
                $display("FAIL ready_after_reset[%0d]: got %b expected 111", d, {awready[d], wready[d], arready[d]});
            end
        end
    endtask

    task automatic test_basic();
        logic [1:0] resp; logic [31:0] data; int edges, lat; bit ok, st;
        rd_exp_t e; logic [1:0] er;
        expect_write(0, 32'h10, 32'hA5A5A5A5, 4'hF);
        do_write(0, 32'h10, 32'hA5A5A5A5, 4'hF, 0, 0, resp, edges, ok, st);
        er = wr_q.pop_front();
        checks++; if (!ok)        begin errors++; $display("FAIL basic_wr_timeout: got 0 expected 1"); end
        checks++; if (edges != 1) begin errors++; $display("FAIL basic_b_latency: got %0d expected 1 edge after capture", edges); end
        checks++; if (resp !== er) begin errors++; $display("FAIL basic_bresp: got %b expected %b", resp, er); end
        expect_read(0, 32'h10);
        do_read(0, 32'h10, 0, data, resp, lat, ok, st);
        e = rd_q.pop_front();
        checks++; if (!ok)     begin errors++; $display("FAIL basic_rd_timeout: got 0 expected 1"); end
        checks++; if (lat != 1) begin errors++; $display("FAIL basic_r_latency: got %0d expected 1", lat); end
        checks++; if (data !== e.data || resp !== e.resp) begin
            errors++; $display("FAIL basic_rdata: got %h/%b expected %h/%b", data, resp, e.data, e.resp);
        end
    endtask

    task automatic test_w_before_aw();
        logic [1:0] resp, er; logic [31:0] data; int edges, lat; bit ok, st; rd_exp_t e;
        expect_write(0, 32'h20, 32'h11223344, 4'hF);
        do_write(0, 32'h20, 32'h11223344, 4'hF, 3, 0, resp, edges, ok, st);
        er = wr_q.pop_front();
        checks++; if (!ok || resp !== er) begin errors++; $display("FAIL w_first_bresp: got %b ok=%0d expected %b", resp, ok, er); end
        expect_write(0, 32'h20, 32'hFFFFFFFF, 4'b0101);
        do_write(0, 32'h20, 32'hFFFFFFFF, 4'b0101, 0, 0, resp, edges, ok, st);
        er = wr_q.pop_front();
        checks++; if (!ok || resp !== er) begin errors++; $display("FAIL strobe_bresp: got %b ok=%0d expected %b", resp, ok, er); end
        expect_read(0, 32'h20);
        do_read(0, 32'h20, 0, data, resp, lat, ok, st);
        e = rd_q.pop_front();
        checks++; if (!ok || data !== e.data || data !== 32'h11FF33FF) begin
            errors++; $display("FAIL strobe_readback: got %h expected %h", data, e.data);
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] resp, er; logic [31:0] data; int edges, lat; bit ok, st; rd_exp_t e;
        expect_write(0, 32'h30, 32'hCAFEF00D, 4'hF);
        do_write(0, 32'h30, 32'hCAFEF00D, 4'hF, 0, 5, resp, edges, ok, st);
        er = wr_q.pop_front();
        checks++; if (!ok || resp !== er) begin errors++; $display("FAIL bp_bresp: got %b expected %b", resp, er); end
        checks++; if (st !== 1'b1) begin errors++; $display("FAIL bp_b_stable: got %0d expected 1", st); end
        expect_read(0, 32'h30);
        do_read(0, 32'h30, 5, data, resp, lat, ok, st);
        e = rd_q.pop_front();
        checks++; if (!ok || data !== e.data) begin errors++; $display("FAIL bp_rdata: got %h expected %h", data, e.data); end
        checks++; if (st !== 1'b1) begin errors++; $display("FAIL bp_r_stable: got %0d expected 1", st); end
    endtask

    task automatic test_out_of_range();
        logic [1:0] resp, er; logic [31:0] data; int edges, lat; bit ok, st; rd_exp_t e;
        logic [31:0] wa [3];
        logic [31:0] wd [3];
        logic [31:0] ra [3];
        wa = '{32'h0, 32'hFFC, 32'h1000};
        wd = '{32'h01020304, 32'h5555AAAA, 32'hDEADBEEF};
        ra = '{32'h1000, 32'h0, 32'hFFC};
        for (int i = 0; i < 3; i++) begin
            expect_write(0, wa[i], wd[i], 4'hF);
            do_write(0, wa[i], wd[i], 4'hF, 0, 0, resp, edges, ok, st);
            er = wr_q.pop_front();
            checks++; if (!ok || resp !== er) begin errors++; $display("FAIL range_bresp@%h: got %b expected %b", wa[i], resp, er); end
        end
        for (int i = 0; i < 3; i++) begin
            expect_read(0, ra[i]);
            do_read(0, ra[i], 0, data, resp, lat, ok, st);
            e = rd_q.pop_front();
            checks++; if (!ok || data !== e.data || resp !== e.resp) begin
                errors++; $display("FAIL range_read@%h: got %h/%b expected %h/%b", ra[i], data, resp, e.data, e.resp);
            end
        end
    endtask

    task automatic test_latency3_collision();
        logic [1:0] resp, wresp, er; logic [31:0] data; int edges, lat; bit ok, wok, st, wst; rd_exp_t e;
        expect_write(1, 32'h14, 32'h0BAD0BAD, 4'hF);
        do_write(1, 32'h14, 32'h0BAD0BAD, 4'hF, 0, 0, resp, edges, ok, st);
        er = wr_q.pop_front();
        checks++; if (!ok || resp !== er) begin errors++; $display("FAIL lat3_wr_bresp: got %b expected %b", resp, er); end
        expect_read(1, 32'h14);
        do_read(1, 32'h14, 0, data, resp, lat, ok, st);
        e = rd_q.pop_front();
        checks++; if (!ok || lat != 3) begin errors++; $display("FAIL lat3_latency: got %0d expected 3", lat); end
        checks++; if (data !== e.data) begin errors++; $display("FAIL lat3_rdata: got %h expected %h", data, e.data); end
        // AR handshakes at E0, write captured at E2 and committed at E3 = read sample edge.
        expect_write(1, 32'h14, 32'h600DF00D, 4'hF);
        expect_read(1, 32'h14);
        fork
            do_read(1, 32'h14, 0, data, resp, lat, ok, st);
            begin
                repeat (2) @(negedge clk);
                do_write(1, 32'h14, 32'h600DF00D, 4'hF, 0, 0, wresp, edges, wok, wst);
            end
        join
        er = wr_q.pop_front();
        e  = rd_q.pop_front();
        checks++; if (!wok || wresp !== er) begin errors++; $display("FAIL collide_bresp: got %b expected %b", wresp, er); end
        checks++; if (!ok || lat != 3 || data !== e.data) begin
            errors++; $display("FAIL collide_rdata: got %h lat=%0d expected %h lat=3", data, lat, e.data);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] resp, er; logic [31:0] data; int edges, lat, n; bit ok, st; rd_exp_t e;
        expect_write(0, 32'h40, 32'h12345678, 4'hF);
        do_write(0, 32'h40, 32'h12345678, 4'hF, 0, 0, resp, edges, ok, st);
        er = wr_q.pop_front();
        checks++; if (!ok || resp !== er) begin errors++; $display("FAIL rstmid_pre_bresp: got %b expected %b", resp, er); end
        n = 0;
        while (!(awready[0] && wready[0]) && n < 20) begin @(negedge clk); n++; end
        checks++; if ({awready[0], wready[0]} !== 2'b11) begin
            errors++; $display("FAIL rstmid_ready: got %b expected 11", {awready[0], wready[0]});
        end
        awaddr[0] = 32'h40; wdata[0] = 32'hFFFFFFFF; wstrb[0] = 4'hF;
        awvalid[0] = 1'b1; wvalid[0] = 1'b1;
        @(negedge clk);
        awvalid[0] = 1'b0; wvalid[0] = 1'b0;
        rst[0] = 1'b1;
        @(negedge clk);
        checks++; if ({bvalid[0], awready[0], wready[0], bresp[0]} !== 5'b0) begin
            errors++; $display("FAIL rstmid_outputs: got %b expected 00000", {bvalid[0], awready[0], wready[0], bresp[0]});
        end
        rst[0] = 1'b0;
        @(negedge clk);
        expect_read(0, 32'h40);
        do_read(0, 32'h40, 0, data, resp, lat, ok, st);
        e = rd_q.pop_front();
        checks++; if (!ok || data !== e.data) begin errors++; $display("FAIL rstmid_readback: got %h expected %h", data, e.data); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] resp, er; logic [31:0] data, a, dv; int edges, lat; bit ok, st; rd_exp_t e;
        logic [31:0] addrs [6];
        for (int i = 0; i < 6; i++) begin
            a = 32'($urandom_range(0, 1023)) << 2;
            dv = $urandom;
            addrs[i] = a;
            expect_write(0, a, dv, 4'hF);
            do_write(0, a, dv, 4'hF, 0, 0, resp, edges, ok, st);
            er = wr_q.pop_front();
            checks++; if (!ok || resp !== er) begin errors++; $display("FAIL b2b_bresp@%h: got %b expected %b", a, resp, er); end
        end
        for (int i = 0; i < 6; i++) expect_read(0, addrs[i]);
        for (int i = 0; i < 6; i++) begin
            do_read(0, addrs[i], 0, data, resp, lat, ok, st);
            e = rd_q.pop_front();
            checks++; if (!ok || data !== e.data || resp !== e.resp) begin
                errors++; $display("FAIL b2b_read@%h: got %h/%b expected %h/%b", addrs[i], data, resp, e.data, e.resp);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_w_before_aw();
        test_backpressure();
        test_out_of_range();
        test_latency3_collision();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_lite_sram_slave.md
Name: axi_lite_sram_slave

Overview:
- Parametrised AXI4-Lite slave wrapping an internal word-organised RAM.
- Next-generation data-memory slave for the RV32I core: byte addressing, configurable depth/width/read latency, full AXI valid/ready compliance, independent AW/W capture, SLVERR on out-of-range accesses.
- Sits between the core's load/store AXI master (or interconnect) and on-chip data RAM.

Parameters:
- DEPTH, 1024, number of RAM words
- AXI_AWIDTH, 32, byte-address width
- AXI_DWIDTH, 32, data width; legal values 32 or 64
- READ_LATENCY, 1, cycles from AR handshake to RVALID; legal 1..4
- BASE_ADDR, 0, byte address mapped to word 0

Ports:
- AXI_ACLK  in  1  clock
- AXI_ARESET  in  1  reset; synchronous, active-high
- AXI_AWADDR  in  AXI_AWIDTH  write byte address
- AXI_AWVALID in 1 / AXI_AWREADY out 1  write-address handshake
- AXI_WDATA  in  AXI_DWIDTH  write data
- AXI_WSTRB  in  AXI_DWIDTH/8  byte enables
- AXI_WVALID in 1 / AXI_WREADY out 1  write-data handshake
- AXI_BRESP  out  2  write response
- AXI_BVALID out 1 / AXI_BREADY in 1  response handshake
- AXI_ARADDR  in  AXI_AWIDTH  read byte address
- AXI_ARVALID in 1 / AXI_ARREADY out 1  read-address handshake
- AXI_RDATA  out  AXI_DWIDTH  read data
- AXI_RRESP  out  2  read response
- AXI_RVALID out 1 / AXI_RREADY in 1  read-data handshake

Behaviour:
- One clock (AXI_ACLK); reset AXI_ARESET synchronous, active-high. All outputs registered.
- Reset values: AWREADY=WREADY=ARREADY=0, BVALID=RVALID=0, BRESP=RRESP=2'b00, RDATA=0. RAM contents not reset. The READY outputs go 1 on the first edge after reset deasserts.
- Address decode: offset = addr - BASE_ADDR; index = offset >> log2(AXI_DWIDTH/8); low offset bits ignored (no misalignment error). In range iff addr >= BASE_ADDR and index < DEPTH, else RESP=2'b10 (SLVERR).
- Write FSM, states W_IDLE, W_RESP:
  - W_IDLE: AWREADY=1 until AW is captured, WREADY=1 until W is captured. AW and W are captured independently, in either order or the same cycle. After capture the matching READY drops.
  - Once both are held, on the next edge: commit the write (only bytes with WSTRB=1, only if in range), set BVALID=1, BRESP=00 or 10, enter W_RESP.
  - W_RESP: BVALID and BRESP held stable until BVALID&BREADY. On that edge BVALID=0, capture flags cleared, return to W_IDLE; READYs reassert on the following edge.
  - WSTRB=0 gives OKAY with no RAM change.
- Read FSM, states R_IDLE, R_LAT, R_DATA:
  - R_IDLE: ARREADY=1. On AR handshake: latch address, ARREADY=0, load latency counter.
  - RVALID rises exactly READY_LATENCY... see next line: RVALID rises exactly READ_LATENCY edges after the handshake edge; R_LAT is skipped when READ_LATENCY=1.
  - RDATA = RAM word (in range) or 0 with RRESP=10 (out of range).
  - R_DATA: RDATA/RRESP/RVALID held until RREADY. On handshake RVALID=0, return to R_IDLE; ARREADY reasserts on the next edge.
- Channels are fully independent; reads and writes may overlap.
- Collision: a write commit and a RAM read sample of the same index on the same edge return the NEW data (write-first).
- Reset mid-transaction: pending AW/W/AR captures discarded. If reset is high on a commit edge, no RAM write occurs. Outputs return to reset values on that edge.
- No outstanding-transaction queueing: at most one write and one read in flight.

Test Plan:
- Reset, then AW=0x10, W=0xA5A5A5A5, WSTRB=F in the same cycle -> BVALID 2 edges later, BRESP=00. Read 0x10 with READ_LATENCY=1 -> RVALID 1 edge after AR handshake, RDATA=0xA5A5A5A5, RRESP=00.
- W issued 3 cycles before AW (addr 0x20, data 0x11223344), then WSTRB=4'b0101 with data 0xFFFFFFFF -> readback 0x11FF33FF.
- Hold BREADY and RREADY low 5 cycles -> BVALID/RVALID, BRESP/RRESP and RDATA stay stable; AWREADY/ARREADY stay 0 until each handshake completes.
- Address (DEPTH*4) with DEPTH=1024, i.e. 0x1000 -> BRESP=10 with no RAM word modified; read returns RRESP=10, RDATA=0.
- READ_LATENCY=3 -> RVALID exactly 3 edges after the AR handshake. A write to index 5 committing on the sample edge of a read of index 5 -> read returns the new data.
- Assert AXI_ARESET after AW+W capture, before the commit edge -> no RAM change, BVALID=0. Readback returns the old value.
